// File: rtl/spmv_row_accum.sv
// Row accumulator for the HHT sparse matrix-vector datapath.
// Multiplies nonzero/vector pairs, sums per row, queues row results.
module spmv_row_accum #(
    parameter int DATA_W     = 32,
    parameter int ACC_W      = 32,
    parameter int ROW_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_mval,
    input  logic [DATA_W-1:0] in_vval,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROW_W-1:0]  out_row,
    output logic [ACC_W-1:0]  out_sum,
    output logic              busy,
    output logic              done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t state, state_nxt;

    logic [ROW_W-1:0] rows_total;
    logic [ROW_W-1:0] row_cnt;
    logic [ROW_W-1:0] row_idx;
    logic             s1_valid;
    logic             s1_last;
    logic [ACC_W-1:0] s1_p;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] prod;
    logic [ACC_W-1:0] sum;
    logic [ROW_W-1:0] mem_row [FIFO_DEPTH];
    logic [ACC_W-1:0] mem_sum [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    need;
    logic             accept;
    logic             push;
    logic             pop;
    logic             final_beat;
    logic             load;

    // Low bits of the product equal the product of the low bits.
    assign prod       = ACC_W'(in_mval) * ACC_W'(in_vval);
    assign sum        = acc + s1_p;
    assign push       = s1_valid & s1_last;
    // A last beat sitting in stage 1 already owns a FIFO slot.
    assign need       = count + CW'(push);
    assign in_ready   = (state == RUN) && (need < CW'(FIFO_DEPTH));
    assign accept     = in_valid & in_ready;
    assign out_valid  = (count != '0);
    assign pop        = out_valid & out_ready;
    assign out_row    = mem_row[rd_ptr];
    assign out_sum    = mem_sum[rd_ptr];
    assign load       = (state == IDLE) & start;
    assign final_beat = accept & in_last
                      & ((row_cnt + ROW_W'(1)) == rows_total);

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nxt = (num_rows == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (final_beat) state_nxt = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (!s1_valid && count == '0) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // Pass bookkeeping: rows expected and rows fully received.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rows_total <= '0;
            row_cnt    <= '0;
        end else if (load) begin
            rows_total <= num_rows;
            row_cnt    <= '0;
        end else if (accept && in_last) begin
            row_cnt <= row_cnt + ROW_W'(1);
        end
    end

    // Stage 1: capture product and last flag of an accepted beat.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_p     <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_last <= in_last;
                s1_p    <= prod;
            end
        end
    end

    // Stage 2: accumulate, or close the row and advance its index.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            acc     <= '0;
            row_idx <= '0;
        end else begin
            if (load) row_idx <= '0;
            if (s1_valid) begin
                if (s1_last) begin
                    acc     <= '0;
                    row_idx <= row_idx + ROW_W'(1);
                end else begin
                    acc <= sum;
                end
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_row[wr_ptr] <= row_idx;
            mem_sum[wr_ptr] <= sum;
        end
    end
endmodule
